// File: rtl/alu_result_fifo.sv
// alu_result_fifo: result queue between the add/sub unit and its consumer.
// Converts sign-magnitude results to two's complement on entry, folds
// negative zero to +0 with zf set, and keeps accept statistics.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   producer handshake
//   in_res[3:0]         sign-magnitude result (bit 3 = sign)
//   in_zf, in_dzf       zero / divide-by-zero flags
//   out_valid/out_ready consumer handshake
//   out_res[3:0]        head result, two's complement (0 when empty)
//   out_zf, out_dzf     head flags (0 when empty)
//   level[3:0]          entries held, 0..DEPTH
//   clr_stat            synchronous clear of acc_cnt / dz_seen
//   acc_cnt[7:0]        saturating count of accepted entries
//   dz_seen             sticky: an accepted entry carried in_dzf
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_res,
    input  logic       in_zf,
    input  logic       in_dzf,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_res,
    output logic       out_zf,
    output logic       out_dzf,
    output logic [3:0] level,
    input  logic       clr_stat,
    output logic [7:0] acc_cnt,
    output logic       dz_seen
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef struct packed {
        logic [3:0] res;
        logic       zf;
        logic       dzf;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        wr_entry;
    entry_t        head;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    level_q, level_d;
    logic [7:0]    acc_q, acc_d;
    logic          dz_q, dz_d;
    // Holds in_ready low through reset and until the first edge after it.
    logic          ready_q, ready_d;

    logic          push;
    logic          pop;
    logic [2:0]    mag;
    logic          neg_zero;

    // Handshakes
    always_comb begin
        in_ready  = ready_q && (level_q < DEPTH_L);
        out_valid = (level_q != 4'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Sign-magnitude to two's complement conversion on the write side
    always_comb begin
        mag      = in_res[2:0];
        neg_zero = (in_res == 4'b1000);
        wr_entry = '0;
        wr_entry.dzf = in_dzf;
        if (neg_zero) begin
            wr_entry.res = 4'b0000;
            wr_entry.zf  = 1'b1;
        end else if (in_res[3]) begin
            wr_entry.res = 4'd0 - {1'b0, mag};
            wr_entry.zf  = in_zf;
        end else begin
            wr_entry.res = {1'b0, mag};
            wr_entry.zf  = in_zf;
        end
    end

    // Pointer / level / statistics next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        acc_d    = acc_q;
        dz_d     = dz_q;
        ready_d  = 1'b1;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase

        // Clear wins over a same-cycle push; the entry is still stored.
        if (clr_stat) begin
            acc_d = 8'd0;
            dz_d  = 1'b0;
        end else if (push) begin
            if (acc_q != 8'hFF) begin
                acc_d = acc_q + 8'd1;
            end
            if (in_dzf) begin
                dz_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 4'd0;
            acc_q    <= 8'd0;
            dz_q     <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            acc_q    <= acc_d;
            dz_q     <= dz_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset; level gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Output side, forced to zero when empty
    always_comb begin
        head    = mem_q[rd_ptr_q];
        out_res = out_valid ? head.res : 4'd0;
        out_zf  = out_valid ? head.zf  : 1'b0;
        out_dzf = out_valid ? head.dzf : 1'b0;
        level   = level_q;
        acc_cnt = acc_q;
        dz_seen = dz_q;
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed scoreboard bench for alu_result_fifo.
// Expected entries are queued on push and compared at the head.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_res;
    logic       in_zf;
    logic       in_dzf;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic       out_zf;
    logic       out_dzf;
    logic [3:0] level;
    logic       clr_stat;
    logic [7:0] acc_cnt;
    logic       dz_seen;

    alu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_res    (in_res),
        .in_zf     (in_zf),
        .in_dzf    (in_dzf),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_zf    (out_zf),
        .out_dzf   (out_dzf),
        .level     (level),
        .clr_stat  (clr_stat),
        .acc_cnt   (acc_cnt),
        .dz_seen   (dz_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors;
    int         miscompares;
    logic [5:0] sb[$];
    int         mlevel;
    logic       mready;
    int         macc;
    logic       mdz;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {res, zf, dzf} the consumer should see for a given input
    function automatic logic [5:0] conv(input logic [3:0] r,
                                        input logic zf, input logic dzf);
        int m;
        int v;
        m = int'(r[2:0]);
        if (r == 4'b1000) return {4'b0000, 1'b1, dzf};
        if (r[3]) v = (16 - m) % 16;
        else      v = m;
        return {4'(v), zf, dzf};
    endfunction

    task automatic step(input logic v, input logic [3:0] r,
                        input logic zf, input logic dzf,
                        input logic ordy, input logic clr);
        logic       push;
        logic       pop;
        logic [5:0] head;
        in_valid  = v;
        in_res    = r;
        in_zf     = zf;
        in_dzf    = dzf;
        out_ready = ordy;
        clr_stat  = clr;
        #1;
        chk("in_ready", 16'(in_ready), 16'(mready && mlevel < DEPTH));
        chk("out_valid", 16'(out_valid), 16'(mlevel > 0));
        head = (sb.size() > 0) ? sb[0] : 6'd0;
        chk("head", 16'({out_res, out_zf, out_dzf}), 16'(head));
        push = v && mready && (mlevel < DEPTH);
        pop  = ordy && (mlevel > 0);
        @(posedge clk);
        if (pop)  void'(sb.pop_front());
        if (push) sb.push_back(conv(r, zf, dzf));
        mlevel = sb.size();
        mready = 1'b1;
        if (clr) begin
            macc = 0;
            mdz  = 1'b0;
        end else if (push) begin
            if (macc < 255) macc++;
            if (dzf) mdz = 1'b1;
        end
        #1;
        chk("level", 16'(level), 16'(mlevel));
        chk("acc_cnt", 16'(acc_cnt), 16'(macc));
        chk("dz_seen", 16'(dz_seen), 16'(mdz));
    endtask

    task automatic check_reset_state();
        chk("rst_level", 16'(level), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_out", 16'({out_res, out_zf, out_dzf}), 16'd0);
        chk("rst_acc", 16'(acc_cnt), 16'd0);
        chk("rst_dz", 16'(dz_seen), 16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int a0;
        vectors     = 0;
        miscompares = 0;
        mlevel      = 0;
        mready      = 1'b0;
        macc        = 0;
        mdz         = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_res      = 4'd0;
        in_zf       = 1'b0;
        in_dzf      = 1'b0;
        out_ready   = 1'b0;
        clr_stat    = 1'b0;
        #2;
        check_reset_state();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // First step: in_ready still low until the edge after release
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two pushes held, then pop: 0011 then 1101 -> 1011
        step(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("two_level", 16'(level), 16'd2);
        chk("first_head", 16'(out_res), 16'b0011);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("second_head", 16'(out_res), 16'b1011);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Negative zero, pushed with out_ready high while empty
        step(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("negzero_zf", 16'({out_res, out_zf}), 16'b00001);
        step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Fill, push against full, pop, fifth entry across the wrap
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_level", 16'(level), 16'(DEPTH));
        step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ready_after_pop", 16'(in_ready), 16'd1);
        step(1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Steady push+pop at level 2
        step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        a0 = macc;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'(i + 3), (i == 4), (i == 7), 1'b1, 1'b0);
            chk("stream_level", 16'(level), 16'd2);
        end
        chk("acc_plus10", 16'(acc_cnt), 16'(a0 + 10));

        // Clear coinciding with a dzf push
        step(1'b1, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_dz", 16'(dz_seen), 16'd0);
        chk("clr_acc", 16'(acc_cnt), 16'd0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_entry_dzf", 16'({out_valid, out_dzf}), 16'b11);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Saturation of acc_cnt
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("acc_sat", 16'(acc_cnt), 16'd255);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset with three entries in flight
        step(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", 16'(level), 16'd3);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_state();
        sb.delete();
        mlevel = 0;
        mready = 1'b0;
        macc   = 0;
        mdz    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
